// File: rtl/pair_accumulator_pkg.sv
// Shared types and arithmetic helpers for the pair accumulator.
// Includes the frame FSM states, input alignment and saturating addition.
package pair_accumulator_pkg;

  typedef enum logic {ACCUM, DONE} state_t;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_t;

  function automatic int align_shift(input int in_exp, input int acc_exp);
    return in_exp - acc_exp;
  endfunction

  // Operands are carried at 64 bits so any legal width can be saturated without wrap.
  function automatic sat_t sat_add(input logic signed [63:0] acc,
                                   input logic signed [63:0] x,
                                   input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    s = acc + x;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_accumulator_lane.sv
// One saturating accumulator lane with a sticky overflow flag.
// The input is aligned to the accumulator exponent by an exact left shift.
module sat_accum_lane
  import pair_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 18,
  parameter int SHIFT     = 0,
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  x,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        ovf
);

  logic signed [63:0] aligned;
  sat_t               nxt;

  always_comb begin
    aligned = 64'(x) <<< SHIFT;
    nxt     = sat_add(64'(acc), aligned, ACC_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= ACC_WIDTH'(nxt.sum);
      ovf <= ovf | nxt.ovf;
    end
  end

endmodule

// File: rtl/pair_accumulator.sv
// Accumulates N_SAMPLES (sum, difference) pairs into two saturating lanes
// and holds each finished frame on a valid/ready output handshake.
module pair_accumulator
  import pair_accumulator_pkg::*;
#(
  parameter int A_WIDTH   = 18,
  parameter int A_EXP     = -10,
  parameter int B_WIDTH   = 19,
  parameter int B_EXP     = -11,
  parameter int ACC_WIDTH = 24,
  parameter int ACC_EXP   = -11,
  parameter int N_SAMPLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [A_WIDTH-1:0]   in_a,
  input  logic signed [B_WIDTH-1:0]   in_b,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [ACC_WIDTH-1:0] acc_a,
  output logic signed [ACC_WIDTH-1:0] acc_b,
  output logic                        ovf_a,
  output logic                        ovf_b,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  if (ACC_EXP > A_EXP || ACC_EXP > B_EXP) begin : g_bad_exp
    $error("pair_accumulator: ACC_EXP must be <= min(A_EXP, B_EXP)");
  end
  if (N_SAMPLES < 1) begin : g_bad_n
    $error("pair_accumulator: N_SAMPLES must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             handshake;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // in_ready and out_valid are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (count == LAST) begin
              state     <= DONE;
              count     <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          count     <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_accum_lane #(
    .IN_WIDTH (A_WIDTH),
    .SHIFT    (align_shift(A_EXP, ACC_EXP)),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lane_a (
    .clk  (clk),
    .rst  (rst),
    .clear(handshake),
    .en   (accept),
    .x    (in_a),
    .acc  (acc_a),
    .ovf  (ovf_a)
  );

  sat_accum_lane #(
    .IN_WIDTH (B_WIDTH),
    .SHIFT    (align_shift(B_EXP, ACC_EXP)),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lane_b (
    .clk  (clk),
    .rst  (rst),
    .clear(handshake),
    .en   (accept),
    .x    (in_b),
    .acc  (acc_b),
    .ovf  (ovf_b)
  );

endmodule

// File: tb/tb_pair_accumulator.sv
// Scoreboard bench for pair_accumulator: directed frames push expected results,
// a negedge monitor pops and compares them at every output handshake.
module tb_pair_accumulator;

  localparam int AW = 18;
  localparam int BW = 19;
  localparam int CW = 20;

  typedef struct {
    int a;
    int b;
    int oa;
    int ob;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic signed [AW-1:0] in_a;
  logic signed [BW-1:0] in_b;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] acc_a;
  logic signed [CW-1:0] acc_b;
  logic                 ovf_a;
  logic                 ovf_b;
  logic                 out_valid;
  logic                 out_ready;

  int   passCount  = 0;
  int   checkCount = 0;
  exp_t sb[$];

  pair_accumulator #(
    .A_WIDTH(AW), .A_EXP(-10), .B_WIDTH(BW), .B_EXP(-11),
    .ACC_WIDTH(CW), .ACC_EXP(-11), .N_SAMPLES(4)
  ) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .acc_a(acc_a), .acc_b(acc_b), .ovf_a(ovf_a), .ovf_b(ovf_b),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one cycle; a valid pair first waits (bounded) until the block is ready.
  task automatic applyStimulus(input int a, input int b, input bit v);
    int n;
    n = 0;
    if (v) begin
      while (!in_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n == 20) checkOutput("in_ready_timeout", 0, 1);
    end
    in_a     = AW'(a);
    in_b     = BW'(b);
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_frame", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("frame_acc_a", int'(acc_a), e.a);
        checkOutput("frame_acc_b", int'(acc_b), e.b);
        checkOutput("frame_ovf_a", int'(ovf_a), e.oa);
        checkOutput("frame_ovf_b", int'(ovf_b), e.ob);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pattern[7];
    int k;
    int n;
    pattern = '{1, 0, 0, 1, 1, 0, 1};

    rst = 1'b1; in_valid = 1'b1; in_a = 18'sd5; in_b = 19'sd5; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_acc_a", int'(acc_a), 0);
    checkOutput("rst_acc_b", int'(acc_b), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", int'(in_ready), 1);

    // Basic back-to-back frame; a is aligned by x2.
    sb.push_back('{800, -200, 0, 0});
    repeat (4) applyStimulus(100, -50, 1'b1);
    checkOutput("done_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Backpressure: frame held while new data is offered.
    out_ready = 1'b0;
    sb.push_back('{56, 12, 0, 0});
    repeat (4) applyStimulus(7, 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 18'sd999; in_b = 19'sd999;
      @(posedge clk);
      #1;
      checkOutput("hold_in_ready", int'(in_ready), 0);
      checkOutput("hold_out_valid", int'(out_valid), 1);
      checkOutput("hold_acc_a", int'(acc_a), 56);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_hs_in_ready", int'(in_ready), 1);

    // Bubbles in in_valid only delay the frame.
    sb.push_back('{20, 0, 0, 0});
    k = 1;
    foreach (pattern[i]) begin
      if (pattern[i] == 1) begin
        applyStimulus(k, 0, 1'b1);
        k++;
      end else begin
        applyStimulus(77, 0, 1'b0);
      end
    end

    // Saturation on both lanes, then a clean frame shows flags cleared.
    sb.push_back('{524287, -524288, 1, 1});
    repeat (4) applyStimulus(131071, -262144, 1'b1);
    sb.push_back('{16, 4, 0, 0});
    repeat (4) applyStimulus(2, 1, 1'b1);

    // Mid-frame reset discards the partial frame.
    repeat (2) applyStimulus(10, 0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_acc_a", int'(acc_a), 0);
    sb.push_back('{8, 0, 0, 0});
    repeat (4) applyStimulus(1, 0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pair_accumulator.md
# pair_accumulator

Sequential stage downstream of the fixed-point sum/difference stage. It consumes the two signed fixed-point results (a = sum, b = difference) over a valid/ready stream and accumulates N_SAMPLES accepted pairs into two saturating accumulators that share one exponent. Each completed frame is presented on a held output handshake. It forms the integrate/decimate step between the add/sub datapath and slower downstream consumers.

## Interface
- A_WIDTH, 18: significand width of input a.
- A_EXP, -10: exponent of input a (value = significand·2^A_EXP).
- B_WIDTH, 19: significand width of input b.
- B_EXP, -11: exponent of input b.
- ACC_WIDTH, 24: significand width of both accumulators.
- ACC_EXP, -11: exponent of both accumulators; must be ≤ min(A_EXP, B_EXP), else elaboration error.
- N_SAMPLES, 4: pairs per frame, ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_a  in  A_WIDTH  signed significand a.
- in_b  in  B_WIDTH  signed significand b.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- acc_a  out  ACC_WIDTH  signed accumulated a, exponent ACC_EXP.
- acc_b  out  ACC_WIDTH  signed accumulated b, exponent ACC_EXP.
- ovf_a, ovf_b  out  1  sticky saturation flags for the current frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream takes the result.

## Operation
- Alignment: each input is sign-extended and shifted left by (A_EXP−ACC_EXP) or (B_EXP−ACC_EXP), respectively. The shift is exact; there is no rounding.
- Accumulation: acc += aligned input, computed at ACC_WIDTH+1 bits, then saturated to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. On any clamp, the lane's ovf flag is set and stays set until the frame is consumed.
- The a and b lanes are independent and are updated in the same cycle.
- States:
  - ACCUM: in_ready=1, out_valid=0. An accept (in_valid & in_ready) updates both accumulators and increments count. An accept when count==N_SAMPLES−1 moves the block to DONE.
  - DONE: in_ready=0, out_valid=1, and acc_*/ovf_* are held stable. in_valid is ignored. When out_ready=1, accumulators, flags and count are cleared and the block returns to ACCUM.
- acc_* outputs show the running value in ACCUM. They are only meaningful while out_valid=1.
- rst in any state, including mid-frame or during DONE: state←ACCUM, acc_a=acc_b=0, ovf_a=ovf_b=0, count=0, out_valid=0. in_ready is 0 while rst=1. A partial frame is discarded.

## Timing
- The accumulator update is visible the cycle after the accept.
- out_valid rises in the cycle after the N_SAMPLES-th accept.
- When out_ready is already high, DONE lasts exactly 1 cycle. in_ready returns the cycle after that handshake.
- Minimum frame period is N_SAMPLES+1 cycles.
- Gaps in in_valid only delay the frame; count advances on accepts only.
- in_ready is a registered function of state and depends on no input, so there is no combinational path from input to in_ready.
- The count counter has ⌈log2(N_SAMPLES)⌉ bits (minimum 1) and never wraps past N_SAMPLES−1.

## Structure
- Package pair_accumulator_pkg holds:
  - the state enum (ACCUM, DONE);
  - the function sat_add(acc, x, width), which returns the saturated sum and an overflow bit;
  - the alignment shift-amount function.
- Sub-module sat_accum_lane (one aligned input, clear, enable, acc, ovf) is instantiated twice, once per lane. Per-lane width and shift are passed as parameters.
- The top level holds the FSM, the count and the handshake.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → in_ready=0, out_valid=0, acc_a=acc_b=0. in_ready=1 in the first cycle after release.
- Basic frame: 4 back-to-back pairs with in_a=100, in_b=−50 → out_valid in the cycle after the 4th accept, with acc_a=800 (a shifted ×2), acc_b=−200, ovf_a=ovf_b=0.
- Backpressure: with the frame done, hold out_ready=0 for 5 cycles while in_valid=1 with new data → acc_*, ovf_* and out_valid are stable, in_ready=0, and nothing is accepted. Raising out_ready gives a fresh frame from 0.
- Bubbles: valid pattern 1,0,0,1,1,0,1 with in_a=1..4, in_b=0 → only 4 accepts; acc_a=2·(1+2+3+4)=20.
- Saturation (ACC_WIDTH=20): 4× in_a=131071 → acc_a=524287, ovf_a=1. Negative case: 4× in_b=−262144 → acc_b=−524288, ovf_b=1. Both flags clear after the handshake.
- Mid-frame reset: 2 accepts of in_a=10, then rst for 1 cycle, then 4 accepts of in_a=1 → acc_a=8 (the earlier partial frame is discarded).
